// File: rtl/alu_logic_pkg.sv
// Shared types for the sliced bitwise logic unit.
package alu_logic_pkg;

  typedef enum logic [1:0] {
    LOP_AND  = 2'd0,
    LOP_OR   = 2'd1,
    LOP_XOR  = 2'd2,
    LOP_ANDN = 2'd3
  } logic_op_e;

  typedef enum logic [1:0] {
    LU_IDLE,
    LU_RUN,
    LU_DONE
  } lu_state_e;

endpackage

// File: rtl/logic_slice.sv
// One SLICE-bit lane of the bitwise op; purely combinational.
module logic_slice
  import alu_logic_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic_op_e        op,
  output logic [SLICE-1:0] y
);

  // Op decode for a single slice.
  always_comb begin
    y = '0;
    case (op)
      LOP_AND:  y = a & b;
      LOP_OR:   y = a | b;
      LOP_XOR:  y = a ^ b;
      LOP_ANDN: y = a & ~b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: latches a bundle, walks it LSB slice
// first through one logic_slice, then holds the result until consumed.
module logic_unit_seq
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic_op_e        op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if ((SLICE <= 0) || (WIDTH % SLICE != 0)) begin : g_bad_slice
    $error("logic_unit_seq: SLICE (%0d) must divide WIDTH (%0d)", SLICE, WIDTH);
  end

  lu_state_e                     state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [NSLICE-1:0][SLICE-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic_op_e                     op_q, op_d;
  logic                          zero_q, zero_d;
  logic                          vld_q, vld_d;
  logic                          rdy_q, rdy_d;
  logic                          busy_q, busy_d;
  logic [SLICE-1:0]              sl_a, sl_b, sl_y;

  // Only the slice selected by the counter reaches the datapath.
  assign sl_a = a_q[cnt_q];
  assign sl_b = b_q[cnt_q];

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .op (op_q),
    .y  (sl_y)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      LU_IDLE: begin
        if (in_valid && rdy_q) begin
          a_d     = in0;
          b_d     = in1;
          op_d    = op;
          cnt_d   = '0;
          state_d = LU_RUN;
        end
      end
      LU_RUN: begin
        res_d[cnt_q] = sl_y;
        if (cnt_q == LAST) begin
          // Flag is taken from the fully assembled result, so it is
          // stable for the whole DONE phase.
          zero_d  = (res_d == '0);
          state_d = LU_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LU_DONE: begin
        if (out_ready) state_d = LU_IDLE;
      end
      default: state_d = LU_IDLE;
    endcase
    // Handshake outputs are registered off the next state so they line up
    // with the state they describe and never glitch.
    rdy_d  = (state_d == LU_IDLE);
    vld_d  = (state_d == LU_DONE);
    busy_d = (state_d != LU_IDLE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LU_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= LOP_AND;
      res_q   <= '0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out       = res_q;
  assign out_zero  = zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed and random checks for logic_unit_seq at SLICE = 8, 32 and 4.
module tb_logic_unit_seq;
  import alu_logic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  in_valid, out_ready, in_ready, out_valid, out_zero, busy;
  logic_op_e   op;
  logic [31:0] in0, in1;
  logic [31:0] out_w [3];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(32), .SLICE(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op(op), .in0(in0), .in1(in1), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out(out_w[0]), .out_zero(out_zero[0]), .busy(busy[0]));

  logic_unit_seq #(.WIDTH(32), .SLICE(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op(op), .in0(in0), .in1(in1), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out(out_w[1]), .out_zero(out_zero[1]), .busy(busy[1]));

  logic_unit_seq #(.WIDTH(32), .SLICE(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .op(op), .in0(in0), .in1(in1), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out(out_w[2]), .out_zero(out_zero[2]), .busy(busy[2]));

  function automatic logic [31:0] model(input logic_op_e o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      LOP_AND:  return a & b;
      LOP_OR:   return a | b;
      LOP_XOR:  return a ^ b;
      default:  return a & ~b;
    endcase
  endfunction

  // Present a bundle to unit k and return just after its acceptance edge.
  task automatic start(input int k, input logic_op_e o, input logic [31:0] a,
                       input logic [31:0] b, output bit ok);
    int n = 0;
    while (!in_ready[k] && n < 32) begin @(posedge clk); #1; n++; end
    ok = in_ready[k];
    op = o; in0 = a; in1 = b; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  // Cycles from acceptance edge until out_valid is seen (bounded).
  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    while (!out_valid[k] && lat < 64) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({in_ready[k], out_valid[k], busy[k], out_zero[k]} !== 4'b1000) begin
        fails++; $display("FAIL reset_flags[%0d]: got %b, expected 1000", k,
                          {in_ready[k], out_valid[k], busy[k], out_zero[k]});
      end
      tests++;
      if (out_w[k] !== 32'h0) begin
        fails++; $display("FAIL reset_out[%0d]: got %h, expected 00000000", k, out_w[k]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_and;
    bit ok; int lat;
    out_ready[0] = 1'b0;
    start(0, LOP_AND, 32'hF0F0_1234, 32'hFF00_FF0F, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL and_accept: got %b, expected 1", ok); end
    wait_valid(0, lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL and_latency: got %0d, expected 4", lat); end
    tests++;
    if (out_w[0] !== 32'hF000_1204) begin
      fails++; $display("FAIL and_out: got %h, expected f0001204", out_w[0]);
    end
    tests++;
    if ({out_zero[0], busy[0], in_ready[0]} !== 3'b010) begin
      fails++; $display("FAIL and_flags: got %b, expected 010", {out_zero[0], busy[0], in_ready[0]});
    end
    consume(0);
    tests++;
    if ({out_valid[0], in_ready[0]} !== 2'b01 || out_w[0] !== 32'hF000_1204) begin
      fails++; $display("FAIL and_after: got v=%b r=%b out=%h, expected v=0 r=1 out=f0001204",
                        out_valid[0], in_ready[0], out_w[0]);
    end
  endtask

  task automatic test_ops;
    logic_op_e   ops [4] = '{LOP_AND, LOP_OR, LOP_XOR, LOP_ANDN};
    logic [31:0] exp [4] = '{32'h0A0A_5050, 32'hAFAF_F5F5, 32'hA5A5_A5A5, 32'hA0A0_0505};
    bit ok; int lat;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start(0, ops[i], 32'hAAAA_5555, 32'h0F0F_F0F0, ok);
      wait_valid(0, lat);
      tests++;
      if (lat !== 4 || out_w[0] !== exp[i]) begin
        fails++; $display("FAIL op%0d_result: got lat=%0d out=%h, expected lat=4 out=%h",
                          i, lat, out_w[0], exp[i]);
      end
      @(posedge clk); #1;
      tests++;
      if ({out_valid[0], in_ready[0]} !== 2'b01) begin
        fails++; $display("FAIL op%0d_one_cycle: got v=%b r=%b, expected v=0 r=1",
                          i, out_valid[0], in_ready[0]);
      end
    end
    out_ready[0] = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok; int lat; bit seen;
    out_ready[0] = 1'b0;
    start(0, LOP_AND, 32'h1234_5678, 32'hEDCB_A987, ok);
    wait_valid(0, lat);
    tests++;
    if (out_w[0] !== 32'h0 || out_zero[0] !== 1'b1) begin
      fails++; $display("FAIL zero_result: got out=%h z=%b, expected out=00000000 z=1",
                        out_w[0], out_zero[0]);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1; op = LOP_OR; in0 = 32'hFFFF_0000 + i; in1 = 32'h1;
      @(posedge clk); #1;
      tests++;
      if ({out_valid[0], out_zero[0], in_ready[0]} !== 3'b110 || out_w[0] !== 32'h0) begin
        fails++; $display("FAIL stall%0d: got v=%b z=%b r=%b out=%h, expected v=1 z=1 r=0 out=00000000",
                          i, out_valid[0], out_zero[0], in_ready[0], out_w[0]);
      end
    end
    in_valid[0] = 1'b0;
    consume(0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[0] || busy[0]) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL stall_ignored: got activity=1, expected 0"); end
  endtask

  task automatic test_reset_mid;
    bit ok; bit seen;
    out_ready[0] = 1'b1;
    start(0, LOP_OR, 32'h1122_3344, 32'h0000_00FF, ok);
    @(posedge clk); #1;
    tests++;
    if (out_w[0][7:0] !== 8'hFF) begin
      fails++; $display("FAIL mid_partial: got %h, expected ff", out_w[0][7:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_w[0] !== 32'h0 || {out_valid[0], in_ready[0], busy[0]} !== 3'b010) begin
      fails++; $display("FAIL mid_reset: got out=%h v=%b r=%b b=%b, expected out=00000000 v=0 r=1 b=0",
                        out_w[0], out_valid[0], in_ready[0], busy[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_result: got out_valid pulse, expected none"); end
    out_ready[0] = 1'b0;
  endtask

  task automatic test_isolation;
    bit ok; int lat;
    out_ready[0] = 1'b0;
    start(0, LOP_XOR, 32'hDEAD_BEEF, 32'h0F0F_0F0F, ok);
    lat = 0;
    while (!out_valid[0] && lat < 64) begin
      op = LOP_AND; in0 = $urandom; in1 = $urandom;
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (lat !== 4 || out_w[0] !== 32'hD1A2_B1E0) begin
      fails++; $display("FAIL isolation: got lat=%0d out=%h, expected lat=4 out=d1a2b1e0", lat, out_w[0]);
    end
    consume(0);
  endtask

  task automatic test_latency_sweep;
    int lats [3] = '{4, 1, 8};
    bit ok; int lat;
    for (int k = 1; k < 3; k++) begin
      out_ready[k] = 1'b0;
      start(k, LOP_ANDN, 32'hCAFE_F00D, 32'h00FF_00FF, ok);
      wait_valid(k, lat);
      tests++;
      if (lat !== lats[k] || out_w[k] !== 32'hCA00_F000) begin
        fails++; $display("FAIL sweep[%0d]: got lat=%0d out=%h, expected lat=%0d out=ca00f000",
                          k, lat, out_w[k], lats[k]);
      end
      consume(k);
    end
  endtask

  task automatic test_random(input int k, input int n, input int explat);
    bit ok; int lat; logic_op_e o; logic [31:0] a, b, e;
    for (int t = 0; t < n; t++) begin
      o = logic_op_e'(2'($urandom_range(0, 3)));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      e = model(o, a, b);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      out_ready[k] = 1'($urandom_range(0, 1));
      start(k, o, a, b, ok);
      wait_valid(k, lat);
      tests++;
      if (!ok || lat !== explat || out_w[k] !== e || out_zero[k] !== (e == 32'h0)) begin
        fails++; $display("FAIL rand[%0d].%0d: got ok=%b lat=%0d out=%h z=%b, expected lat=%0d out=%h z=%b",
                          k, t, ok, lat, out_w[k], out_zero[k], explat, e, (e == 32'h0));
      end
      if (!out_ready[k]) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      consume(k);
      tests++;
      if (out_valid[k] !== 1'b0) begin
        fails++; $display("FAIL rand_drop[%0d].%0d: got out_valid=%b, expected 0", k, t, out_valid[k]);
      end
    end
  endtask

  initial begin
    in_valid = '0; out_ready = '0; op = LOP_AND; in0 = '0; in1 = '0;
    test_reset();
    test_and();
    test_ops();
    test_backpressure();
    test_reset_mid();
    test_isolation();
    test_latency_sweep();
    test_random(0, 1000, 4);
    test_random(1, 100, 1);
    test_random(2, 100, 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
